// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg: shared definitions for the RV64M iterative divider.
//   - DIVControl field positions
//   - FSM state encoding
//   - most-negative constants used by the overflow check
//   - sext32: sign-extend a 32-bit value to the datapath width
package riscv_div_pkg;

  localparam int DIV_XLEN     = 64;
  localparam int DIV_WORD_BIT = 2;
  localparam int DIV_REM_BIT  = 1;
  localparam int DIV_UNS_BIT  = 0;

  localparam logic [DIV_XLEN-1:0] XLEN_MIN = {1'b1, {(DIV_XLEN-1){1'b0}}};
  localparam logic [31:0]         W_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic [DIV_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(DIV_XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/riscv_divider_if.sv
// riscv_divider_if: execute-stage <-> divider request/response bundle.
//   master (pipeline): start, flush, rs1, rs2, DIVControl -> ; <- busy, done, result
//   slave  (divider) : mirror image
interface riscv_divider_if #(parameter int XLEN = 64);
  logic            start;
  logic            flush;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      DIVControl;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, flush, rs1, rs2, DIVControl,
                  input  busy, done, result);
  modport slave  (input  start, flush, rs1, rs2, DIVControl,
                  output busy, done, result);
endinterface

// File: rtl/riscv_div_step.sv
// riscv_div_step: one combinational radix-2 non-restoring iteration.
//   rem_in  [W:0]   signed partial remainder
//   quo_in  [W-1:0] dividend bits still to shift in / quotient bits so far
//   divisor [W-1:0] divisor magnitude
//   rem_out, quo_out: state after one shift + add/subtract
module riscv_div_step #(parameter int W = 64) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic [W-1:0] quo_out
);
  logic [W:0] w_shift;

  always_comb begin
    w_shift = {rem_in[W-1:0], quo_in[W-1]};
    // Negative partial remainder: add instead of restoring. The result always
    // fits W+1 bits, so wrap-around of the shifted value is harmless.
    rem_out = rem_in[W] ? (w_shift + {1'b0, divisor}) : (w_shift - {1'b0, divisor});
    // Quotient bit equals what a restoring divider would produce.
    quo_out = {quo_in[W-2:0], ~rem_out[W]};
  end
endmodule

// File: rtl/riscv_divider.sv
// riscv_divider: iterative RV64M divide unit (DIV/DIVU/REM/REMU + W forms).
//   clk, rst  : clock, synchronous active-high reset
//   bus       : riscv_divider_if.slave (start/flush/rs1/rs2/DIVControl in,
//               busy/done/result out)
// One quotient bit per cycle; divide-by-zero and signed overflow finish
// straight from IDLE. Operands are reduced to magnitudes up front and signs
// are reapplied when the result is registered on entry to DONE, so done and
// result line up in the same cycle.
module riscv_divider
  import riscv_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic           clk,
  input  logic           rst,
  riscv_divider_if.slave bus
);
  div_state_t      r_state, w_next;
  logic            r_word, r_rem_sel, r_q_neg, r_r_neg;
  logic [6:0]      r_count;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo, r_divisor, r_result;

  // launch-side decode
  logic            w_word, w_uns, w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_a, w_b, w_a_abs, w_b_abs, w_spec_sel, w_spec_res;
  // finish-side
  logic [XLEN:0]   w_rem;
  logic [XLEN-1:0] w_quo, w_rem_fix, w_q_mag, w_q, w_r, w_sel, w_fin_res;

  riscv_div_step #(.W(XLEN)) u_step (
    .rem_in (r_rem),
    .quo_in (r_quo),
    .divisor(r_divisor),
    .rem_out(w_rem),
    .quo_out(w_quo)
  );

  always_comb begin
    w_word  = bus.DIVControl[DIV_WORD_BIT];
    w_uns   = bus.DIVControl[DIV_UNS_BIT];
    w_a     = w_word ? (w_uns ? {32'b0, bus.rs1[31:0]} : sext32(bus.rs1[31:0])) : bus.rs1;
    w_b     = w_word ? (w_uns ? {32'b0, bus.rs2[31:0]} : sext32(bus.rs2[31:0])) : bus.rs2;
    w_a_neg = ~w_uns & w_a[XLEN-1];
    w_b_neg = ~w_uns & w_b[XLEN-1];
    w_a_abs = w_a_neg ? -w_a : w_a;
    w_b_abs = w_b_neg ? -w_b : w_b;
    w_div0  = (w_b == '0);
    w_ovf   = ~w_uns & (&w_b) & (w_a == (w_word ? sext32(W_MIN) : XLEN_MIN));
    w_special = w_div0 | w_ovf;
    if (bus.DIVControl[DIV_REM_BIT]) w_spec_sel = w_div0 ? w_a : '0;
    else                             w_spec_sel = w_div0 ? '1  : w_a;
    w_spec_res = w_word ? sext32(w_spec_sel[31:0]) : w_spec_sel;

    // Last iteration's step output feeds the result register directly.
    w_rem_fix = w_rem[XLEN-1:0] + (w_rem[XLEN] ? r_divisor : '0);
    w_q_mag   = r_word ? {32'b0, w_quo[31:0]} : w_quo;
    w_q       = r_q_neg ? -w_q_mag : w_q_mag;
    w_r       = r_r_neg ? -w_rem_fix : w_rem_fix;
    w_sel     = r_rem_sel ? w_r : w_q;
    w_fin_res = r_word ? sext32(w_sel[31:0]) : w_sel;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = w_special ? DONE : CALC;
      CALC:    if (r_count == 7'd1) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.flush) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word    <= 1'b0;
      r_rem_sel <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
    end else if (!bus.flush) begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_word    <= w_word;
          r_rem_sel <= bus.DIVControl[DIV_REM_BIT];
          r_q_neg   <= w_a_neg ^ w_b_neg;
          r_r_neg   <= w_a_neg;
          r_count   <= w_word ? 7'd32 : 7'd64;
          r_rem     <= '0;
          // Word dividends sit in the top half so 32 shifts drain them.
          r_quo     <= w_word ? {w_a_abs[31:0], 32'b0} : w_a_abs;
          r_divisor <= w_b_abs;
          if (w_special) r_result <= w_spec_res;
        end
        CALC: begin
          r_rem   <= w_rem;
          r_quo   <= w_quo;
          r_count <= r_count - 7'd1;
          if (r_count == 7'd1) r_result <= w_fin_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.result = r_result;

endmodule

// File: tb/tb_riscv_divider.sv
module tb_riscv_divider;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [2:0] DIV = 3'b000, DIVU = 3'b001, REM = 3'b010, REMU = 3'b011,
                         DIVW = 3'b100, DIVUW = 3'b101, REMW = 3'b110;

  riscv_divider_if #(.XLEN(64)) bus ();
  riscv_divider #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called in an IDLE cycle (cycle 0). Returns in the IDLE cycle after done.
  task automatic run_op(input string tag, input logic [2:0] ctl, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat);
    int  cyc;
    logic seen, busy_bad;
    bus.start = 1'b1; bus.DIVControl = ctl; bus.rs1 = a; bus.rs2 = b;
    tick();
    bus.start = 1'b0; bus.rs1 = 64'hDEAD_BEEF_0BAD_F00D; bus.rs2 = 64'h0123_4567_89AB_CDEF;
    bus.DIVControl = 3'b111;
    cyc = 1; seen = 1'b0; busy_bad = 1'b0;
    while (!seen && cyc < 200) begin
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      if (bus.done === 1'b1) seen = 1'b1;
      else begin cyc++; tick(); end
    end
    chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_res"}, bus.result, exp);
    tick();
    chk({tag, "_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    chk({tag, "_hold"}, bus.result, exp);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0; bus.DIVControl = '0;
    tick(); tick();
    chk("reset_out", {bus.result[61:0], bus.done, bus.busy}, 64'd0);
    rst = 1'b0;
    tick();

    run_op("div_m7_2",   DIV,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_m7_2",   REM,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu_100_7", DIVU, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu_100_7", REMU, 64'd100, 64'd7, 64'd2, 65);
    run_op("divu_big",   DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    run_op("div_by0",    DIV,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem_by0",    REM,  64'd5, 64'd0, 64'd5, 1);
    run_op("divuw_by0",  DIVUW, 64'h0000_1234_0000_0005, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("div_ovf",    DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf",    REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("divw_ovf",   DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("divuw_ff_1", DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("remw_m7_3",  REMW, 64'hAAAA_0000_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Flush in cycle 10 of a DIV: no done, previous result kept.
    bus.start = 1'b1; bus.DIVControl = DIV; bus.rs1 = 64'd1000; bus.rs2 = 64'd3;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_idle", {62'd0, bus.done, bus.busy}, 64'd0);
    chk("flush_hold", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
    seen = 1'b0;
    repeat (70) begin
      if (bus.done === 1'b1) seen = 1'b1;
      tick();
    end
    chk("flush_nodone", 64'(seen), 64'd0);

    // Reset in cycle 20: everything cleared, then a fresh op works.
    bus.start = 1'b1; bus.DIVControl = DIVU; bus.rs1 = 64'd1000; bus.rs2 = 64'd3;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid", {bus.result[61:0], bus.done, bus.busy}, 64'd0);
    tick();
    run_op("after_rst",  DIVU, 64'd1000, 64'd3, 64'd333, 65);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
